muldiv_unit: RTL and testbench

Iterative 32-bit unsigned multiply/divide unit for the RISC core's execute stage. It takes two 32-bit operands, runs a radix-2 shift-add or restoring-divide loop for 32 cycles, and presents a registered 32-bit result. That result drives the execute-side 2:1 result-select mux, which chooses between this unit and the ALU path. A start/busy/done handshake lets the control unit stall the pipeline while an operation is in flight.

---
 rtl/muldiv_unit_if.sv | 21 ++
 rtl/muldiv_unit.sv | 151 +++++++++++++++
 tb/tb_muldiv_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake and operand/result bundle between the control unit and muldiv_unit.
// master drives the request side; slave is the multiply/divide unit.
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] result;
  logic        busy;
  logic        done;

  modport master (
    output start, op, A, B,
    input  result, busy, done
  );

  modport slave (
    input  start, op, A, B,
    output result, busy, done
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit unsigned MUL/MULHU/DIVU/REMU unit: radix-2 shift-add or restoring divide.
// Define MULDIV_DIV_EN to build the divider; otherwise ops 10/11 return 0 via the fast path.
module muldiv_unit (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] opnd_q, opnd_d;      // multiplicand for MUL*, divisor for DIV*
  logic [63:0] prod_q, prod_d;      // product; low half doubles as dividend/quotient
  logic [4:0]  count_q, count_d;
  logic [31:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [32:0] mul_sum;
  logic [63:0] mul_prod;
  logic        fast;
  logic [31:0] fast_res;
  logic [31:0] run_res;

  assign mul_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_prod = {mul_sum, prod_q[31:1]};

`ifdef MULDIV_DIV_EN
  logic [32:0] rem_q, rem_d;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic        div_ge;
  logic [32:0] div_rem;
  logic [31:0] div_quo;

  assign div_shift = {rem_q[31:0], prod_q[31]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
  assign div_ge    = ~div_diff[33];
  assign div_rem   = div_ge ? div_diff[32:0] : div_shift;
  assign div_quo   = {prod_q[30:0], div_ge};

  assign fast     = bus.op[1] && (bus.B == 32'd0);
  assign fast_res = bus.op[0] ? bus.A : 32'hFFFF_FFFF;

  always_comb begin
    unique case (op_q)
      2'b00:   run_res = mul_prod[31:0];
      2'b01:   run_res = mul_prod[63:32];
      2'b10:   run_res = div_quo;
      default: run_res = div_rem[31:0];
    endcase
  end
`else
  assign fast     = bus.op[1];
  assign fast_res = 32'd0;

  always_comb begin
    unique case (op_q)
      2'b00:   run_res = mul_prod[31:0];
      2'b01:   run_res = mul_prod[63:32];
      default: run_res = 32'd0;
    endcase
  end
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    count_d  = count_q;
    result_d = result_q;
`ifdef MULDIV_DIV_EN
    rem_d    = rem_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d   = bus.op;
          opnd_d = bus.op[1] ? bus.B : bus.A;
          prod_d = {32'd0, bus.op[1] ? bus.A : bus.B};
`ifdef MULDIV_DIV_EN
          rem_d  = 33'd0;
`endif
          if (fast) begin
            state_d  = StDone;
            result_d = fast_res;
          end else begin
            state_d = StRun;
            count_d = 5'd31;
          end
        end
      end
      StRun: begin
        prod_d = mul_prod;
`ifdef MULDIV_DIV_EN
        if (op_q[1]) begin
          prod_d = {32'd0, div_quo};
          rem_d  = div_rem;
        end
`endif
        if (count_q == 5'd0) begin
          state_d  = StDone;
          result_d = run_res;
        end else begin
          count_d = count_q - 5'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= 2'd0;
      opnd_q   <= 32'd0;
      prod_q   <= 64'd0;
      count_q  <= 5'd0;
      result_q <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem_q    <= 33'd0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      count_q  <= count_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MULDIV_DIV_EN
      rem_q    <= rem_d;
`endif
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
// Honours MULDIV_DIV_EN the same way the design does.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
`ifdef MULDIV_DIV_EN
      2'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd3: return (b == 0) ? a : a % b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
    return (op[1] && b == 0) ? 1 : 33;
`else
    return op[1] ? 1 : 33;
`endif
  endfunction

  // Called one step after a clock edge with the unit idle; returns likewise, DUT idle again.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int          cyc;
    logic [31:0] exp;
    exp = ref_result(op, a, b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.A     = $urandom;
    bus.B     = $urandom;
    check_eq({tag, "/busy1"}, 32'(bus.busy), 32'd1);
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({tag, "/lat"}, 32'(cyc), 32'(ref_latency(op, b)));
    check_eq({tag, "/res"}, bus.result, exp);
    check_eq({tag, "/busyd"}, 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    check_eq({tag, "/idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
    check_eq({tag, "/hold"}, bus.result, exp);
  endtask

  initial begin
    int          dones;
    int          first_done;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst/state", {bus.result[31:2] | 30'd0, bus.busy, bus.done}, 32'd0);
    check_eq("rst/result", bus.result, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst/after", {30'd0, bus.busy, bus.done}, 32'd0);

    run_op("mul7x6", 2'd0, 32'd7, 32'd6);
    run_op("mulhu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul_ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("divu100_7", 2'd2, 32'd100, 32'd7);
    run_op("remu100_7", 2'd3, 32'd100, 32'd7);
    run_op("divu_by0", 2'd2, 32'h1234, 32'd0);
    run_op("remu_by0", 2'd3, 32'h1234, 32'd0);
    run_op("divu_big", 2'd2, 32'hFFFF_FFFF, 32'd1);
    run_op("remu_big", 2'd3, 32'h8000_0001, 32'hFFFF_FFFF);

    // A start issued mid-operation must be dropped, not queued.
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.A     = 32'd3;
    bus.B     = 32'd5;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    dones      = 0;
    first_done = 0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 10) begin
        bus.start = 1'b1;
        bus.op    = 2'd2;
        bus.A     = $urandom;
        bus.B     = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        dones++;
        if (first_done == 0) first_done = c;
      end
      @(posedge clk); #1;
    end
    check_eq("ign/dones", 32'(dones), 32'd1);
    check_eq("ign/lat", 32'(first_done), 32'd33);
    check_eq("ign/res", bus.result, 32'd15);
    check_eq("ign/busy", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of an operation.
    run_op("mul_pre", 2'd0, 32'h1234, 32'h10);
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.A     = 32'd9;
    bus.B     = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("abort/flags", {30'd0, bus.busy, bus.done}, 32'd0);
    check_eq("abort/result", bus.result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("abort/nodone", {30'd0, bus.busy, bus.done}, 32'd0);
    run_op("post_rst", 2'd0, 32'd11, 32'd13);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), rop, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
